multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the SimpleCPU datapath. Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over 3-5+ cycles.
- Drives per-cycle datapath enables and selects.
- Waits on a ready handshake from variable-latency memory.
- Supports start/halt through a run input.

Parameters:
- CNT_W, 32, width of retired-instruction counter (optional feature only)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level: 1 = execute instructions, 0 = halt at instruction boundary
- OpCode  in  6  IR[31:26]; stable from DECODE until the instruction ends
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data: 1 = MDR, 0 = ALUOut
- RegDst  out  1  destination: 1 = rd, 0 = rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = reg A
- ALUSrcB  out  2  00 = reg B, 01 = const 4, 10 = immediate, 11 = immediate<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct field
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an undefined opcode
- state  out  4  current state, for debug

Behaviour:
- Opcodes: R 000000, ADDIU 001100, SUBIU 001101, SW 010000, LW 010001, BEQ 010011, J 011100.
- States (encoding): IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, I_EXEC 9, I_WB 10, BRANCH 11, JUMP 12. Codes 13-15 are unreachable and map to IDLE.
- Outputs are decoded from state. Every output not listed for a state is 0.
- Reset: state = IDLE; all outputs 0.
- IDLE: run = 1 -> FETCH; otherwise stay.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite and PCWrite assert only in the cycle where mem_ready = 1; then -> DECODE.
  - mem_ready = 0: hold state, hold request.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (precompute branch target). Next state by opcode:
  - LW/SW -> MEM_ADDR; R -> R_EXEC; ADDIU/SUBIU -> I_EXEC; BEQ -> BRANCH; J -> JUMP.
  - Other opcodes: illegal_op = 1, instr_done = 1; -> FETCH if run = 1, else IDLE.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: MemRead = 1, IorD = 1. Wait for mem_ready, then -> MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Instruction ends.
- MEM_WR: MemWrite = 1, IorD = 1. Instruction ends in the mem_ready cycle.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> R_WB.
- R_WB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Instruction ends.
- I_EXEC: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00 for ADDIU, 01 for SUBIU -> I_WB.
- I_WB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Instruction ends.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Instruction ends.
- JUMP: PCWrite = 1, PCSource = 10. Instruction ends.
- "Instruction ends": instr_done = 1 that cycle; next state FETCH if run = 1, else IDLE.
- run is sampled only at instruction end and in IDLE. Deasserting run mid-instruction never aborts it.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- No timeout: a stalled memory holds the controller indefinitely.
- rst_n low in any state, including mid memory wait: immediate return to IDLE, all outputs 0.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined:
  - Adds output retired_cnt [CNT_W-1:0], reset to 0.
  - Increments on every instr_done except illegal_op cycles.
  - Wraps to 0 at all-ones.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset, run = 1, R-type with mem_ready tied 1 -> states 0,1,2,7,8,1. RegWrite = 1 and RegDst = 1 only in R_WB. instr_done exactly once.
- LW with mem_ready delayed 3 cycles in MEM_RD -> MemRead, IorD = 1 held 4 cycles, then MEM_WB with MemtoReg = 1. Total 8 cycles FETCH to FETCH.
- SW then BEQ -> MemWrite only in MEM_WR. BEQ cycle shows PCWriteCond = 1, ALUOp = 01, PCSource = 01, with no RegWrite anywhere in either instruction.
- SUBIU then J -> I_EXEC shows ALUOp = 01. JUMP shows PCWrite = 1, PCSource = 10 and returns to FETCH.
- OpCode 111111 -> illegal_op pulse in DECODE, back to FETCH. With INSTR_COUNT_EN, retired_cnt unchanged.
- run dropped during R_EXEC -> R_WB completes, then IDLE, outputs all 0. rst_n pulsed low during FETCH wait -> IDLE immediately, MemRead = 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the SimpleCPU datapath.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module multicycle_control
`ifdef INSTR_COUNT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] OpCode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
`ifdef INSTR_COUNT_EN
  output logic [CNT_W-1:0] retired_cnt,
`endif
  output logic [3:0] state
);

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001100;
  localparam logic [5:0] OP_SUBIU = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_LW    = 6'b010001;
  localparam logic [5:0] OP_BEQ   = 6'b010011;
  localparam logic [5:0] OP_J     = 6'b011100;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  state_t cur_state, nxt_state;

  assign state = cur_state;

  // Outputs are a pure decode of the current state; only FETCH/MEM_WR qualify on mem_ready.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    nxt_state   = cur_state;
    case (cur_state)
      S_IDLE: if (run) nxt_state = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (OpCode)
          OP_LW, OP_SW:       nxt_state = S_MEM_ADDR;
          OP_R:               nxt_state = S_R_EXEC;
          OP_ADDIU, OP_SUBIU: nxt_state = S_I_EXEC;
          OP_BEQ:             nxt_state = S_BRANCH;
          OP_J:               nxt_state = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nxt_state = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) nxt_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        nxt_state = S_R_WB;
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = (OpCode == OP_SUBIU) ? 2'b01 : 2'b00;
        nxt_state = S_I_WB;
      end
      S_I_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: nxt_state = S_IDLE;
    endcase
    // run is only consulted at the instruction boundary, so a drop never aborts mid-flight.
    if (instr_done) nxt_state = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

`ifdef INSTR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       retired_cnt <= '0;
    else if (instr_done && !illegal_op) retired_cnt <= retired_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle
// against hand-written per-state output vectors.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [5:0] OpCode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
`ifdef INSTR_COUNT_EN
  logic [31:0] retired_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .run(run), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
`ifdef INSTR_COUNT_EN
    .retired_cnt(retired_cnt),
`endif
    .state(state)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
  //  ALUSrcA,ALUSrcB,ALUOp,PCSource,instr_done,illegal_op}
  wire [17:0] outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};

  localparam logic [17:0] O_IDLE    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_F_WAIT  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] O_F_RDY   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] O_DEC     = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] O_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_1;
  localparam logic [17:0] O_MADDR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] O_MRD     = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_MWB     = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] O_MWR_W   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_MWR_R   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] O_REXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] O_RWB     = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] O_IEX_ADD = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] O_IEX_SUB = 18'b0_0_0_0_0_0_0_0_0_1_10_01_00_0_0;
  localparam logic [17:0] O_IWB     = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] O_BR      = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] O_JMP     = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Check state and all outputs mid-cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] o);
    #1;
    check({tag, ".state"}, {28'd0, state}, {28'd0, st});
    check({tag, ".outs"}, {14'd0, outs}, {14'd0, o});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst.state", {28'd0, state}, 32'd0);
    check("rst.outs", {14'd0, outs}, 32'd0);
`ifdef INSTR_COUNT_EN
    check("rst.cnt", retired_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("idle_halt", 4'd0, O_IDLE);

    // R-type, memory always ready
    run = 1'b1; mem_ready = 1'b1; OpCode = 6'b000000;
    cyc("r.idle", 4'd0, O_IDLE);
    cyc("r.fetch", 4'd1, O_F_RDY);
    cyc("r.dec", 4'd2, O_DEC);
    cyc("r.exec", 4'd7, O_REXEC);
    cyc("r.wb", 4'd8, O_RWB);

    // LW with three stall cycles in MEM_RD
    OpCode = 6'b010001;
    cyc("lw.fetch", 4'd1, O_F_RDY);
    cyc("lw.dec", 4'd2, O_DEC);
    cyc("lw.addr", 4'd3, O_MADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw.rd_wait", 4'd4, O_MRD);
    mem_ready = 1'b1;
    cyc("lw.rd_rdy", 4'd4, O_MRD);
    cyc("lw.wb", 4'd5, O_MWB);

    // SW with a fetch stall and a write stall, then BEQ
    OpCode = 6'b010000; mem_ready = 1'b0;
    cyc("sw.fetch_wait", 4'd1, O_F_WAIT);
    mem_ready = 1'b1;
    cyc("sw.fetch", 4'd1, O_F_RDY);
    cyc("sw.dec", 4'd2, O_DEC);
    cyc("sw.addr", 4'd3, O_MADDR);
    mem_ready = 1'b0;
    cyc("sw.wr_wait", 4'd6, O_MWR_W);
    mem_ready = 1'b1;
    cyc("sw.wr_rdy", 4'd6, O_MWR_R);
    OpCode = 6'b010011;
    cyc("beq.fetch", 4'd1, O_F_RDY);
    cyc("beq.dec", 4'd2, O_DEC);
    cyc("beq.br", 4'd11, O_BR);

    // SUBIU then J
    OpCode = 6'b001101;
    cyc("subiu.fetch", 4'd1, O_F_RDY);
    cyc("subiu.dec", 4'd2, O_DEC);
    cyc("subiu.exec", 4'd9, O_IEX_SUB);
    cyc("subiu.wb", 4'd10, O_IWB);
    OpCode = 6'b011100;
    cyc("j.fetch", 4'd1, O_F_RDY);
    cyc("j.dec", 4'd2, O_DEC);
    cyc("j.jump", 4'd12, O_JMP);

    // Undefined opcode
    OpCode = 6'b111111;
    cyc("ill.fetch", 4'd1, O_F_RDY);
`ifdef INSTR_COUNT_EN
    check("cnt.before_ill", retired_cnt, 32'd6);
`endif
    cyc("ill.dec", 4'd2, O_DEC_ILL);
`ifdef INSTR_COUNT_EN
    check("cnt.after_ill", retired_cnt, 32'd6);
`endif

    // ADDIU uses ALUOp add
    OpCode = 6'b001100;
    cyc("addiu.fetch", 4'd1, O_F_RDY);
    cyc("addiu.dec", 4'd2, O_DEC);
    cyc("addiu.exec", 4'd9, O_IEX_ADD);
    cyc("addiu.wb", 4'd10, O_IWB);

    // run dropped during R_EXEC: finishes the instruction, then halts
    OpCode = 6'b000000;
    cyc("rh.fetch", 4'd1, O_F_RDY);
    cyc("rh.dec", 4'd2, O_DEC);
    run = 1'b0;
    cyc("rh.exec", 4'd7, O_REXEC);
    cyc("rh.wb", 4'd8, O_RWB);
    cyc("rh.idle0", 4'd0, O_IDLE);
    cyc("rh.idle1", 4'd0, O_IDLE);
`ifdef INSTR_COUNT_EN
    check("cnt.final", retired_cnt, 32'd8);
`endif

    // Reset asserted while FETCH waits on memory
    run = 1'b1; mem_ready = 1'b0;
    cyc("rst.idle", 4'd0, O_IDLE);
    cyc("rst.fetch_wait0", 4'd1, O_F_WAIT);
    #1;
    check("rst.pre_state", {28'd0, state}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst.async_state", {28'd0, state}, 32'd0);
    check("rst.async_memread", {31'd0, MemRead}, 32'd0);
    check("rst.async_outs", {14'd0, outs}, 32'd0);
`ifdef INSTR_COUNT_EN
    check("rst.async_cnt", retired_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    check("rst.held_state", {28'd0, state}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
